// File: rtl/bp_pkg.sv
// Shared types for the BTB predictor: counter states, table entry, pipeline
// metadata, table write operations and the 2-bit counter transition function.
package bp_pkg;

  localparam int BP_ENTRIES = 32;
  localparam int BP_XLEN    = 32;
  localparam int BP_IDX_W   = 5;
  localparam int BP_TAG_W   = BP_XLEN - BP_IDX_W - 2;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_state_t;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    bp_state_t           state;
  } btb_entry_t;

  typedef struct packed {
    logic               valid;
    logic [BP_XLEN-1:0] pc;
    logic               pred_taken;
    logic [BP_XLEN-1:0] pred_next;
    logic               hit;
  } bp_meta_t;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_UPDATE,
    WR_ALLOC,
    WR_KILL
  } btb_wr_op_t;

  function automatic bp_state_t bp_next_state(input bp_state_t state, input logic taken);
    bp_state_t next;
    unique case (state)
      SNT:     next = taken ? WNT : SNT;
      WNT:     next = taken ? ST  : SNT;
      WT:      next = taken ? ST  : SNT;
      ST:      next = taken ? ST  : WT;
      default: next = SNT;
    endcase
    return next;
  endfunction

endpackage

// File: rtl/btb_array.sv
// BTB entry storage: one asynchronous lookup port and one synchronous write
// port that applies an update, allocate or kill operation to a single entry.
module btb_array
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int IDX_W   = BP_IDX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    rd_idx,
  output btb_entry_t          rd_entry,
  input  btb_wr_op_t          wr_op,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [BP_TAG_W-1:0] wr_tag,
  input  logic [BP_XLEN-1:0]  wr_target,
  input  logic                wr_taken
);

  btb_entry_t mem [ENTRIES];

  assign rd_entry = mem[rd_idx];

  // NOTE: the whole table is cleared by reset so that no stale entry can hit
  // after a reset; this costs a reset flop per bit instead of a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
    end else begin
      unique case (wr_op)
        WR_UPDATE: begin
          mem[wr_idx].state <= bp_next_state(mem[wr_idx].state, wr_taken);
          if (wr_taken) mem[wr_idx].target <= wr_target;
        end
        WR_ALLOC: mem[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target, state: WT};
        WR_KILL:  mem[wr_idx].valid <= 1'b0;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Branch target buffer with 2-bit direction counters: IF lookup, IF->ID->EX
// metadata pipe, EX resolution/redirect, table update and perf counters.
module btb_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int XLEN    = BP_XLEN,
  parameter int IDX_W   = BP_IDX_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  input  logic            if_valid,
  input  logic            stall,
  input  logic            ex_is_branch,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [15:0]     br_cnt,
  output logic [15:0]     mp_cnt
);

  btb_entry_t rd_entry;
  logic       lookup_hit;
  bp_meta_t   if_meta, id_meta, ex_meta;
  logic       resolve;
  logic [XLEN-1:0] actual_next;
  btb_wr_op_t wr_op;
  logic       unused_pred_taken;

  btb_array #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (if_pc[IDX_W+1:2]),
    .rd_entry  (rd_entry),
    .wr_op     (wr_op),
    .wr_idx    (ex_meta.pc[IDX_W+1:2]),
    .wr_tag    (ex_meta.pc[XLEN-1:IDX_W+2]),
    .wr_target (ex_target),
    .wr_taken  (ex_taken)
  );

  assign lookup_hit  = rd_entry.valid && (rd_entry.tag == if_pc[XLEN-1:IDX_W+2]);
  assign pred_taken  = if_valid && lookup_hit && rd_entry.state[1];
  assign pred_target = pred_taken ? rd_entry.target : if_pc + XLEN'(4);

  assign if_meta = '{valid: if_valid, pc: if_pc, pred_taken: pred_taken,
                     pred_next: pred_target, hit: lookup_hit};

  // A stalled EX slot never resolves, which also defers any mispredict.
  assign resolve     = ex_meta.valid && !stall;
  assign actual_next = (ex_is_branch && ex_taken) ? ex_target : ex_meta.pc + XLEN'(4);
  assign mispredict  = resolve && (actual_next != ex_meta.pred_next);
  assign redirect_pc = resolve ? actual_next : '0;

  // The direction is fully captured by pred_next; the flag rides along for debug.
  assign unused_pred_taken = ex_meta.pred_taken;

  always_comb begin
    wr_op = WR_NONE;
    if (resolve) begin
      if (ex_is_branch) begin
        if (ex_meta.hit)   wr_op = WR_UPDATE;
        else if (ex_taken) wr_op = WR_ALLOC;
      end else if (ex_meta.hit) begin
        wr_op = WR_KILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_meta <= '0;
      ex_meta <= '0;
    end else if (!stall) begin
      if (mispredict) begin
        id_meta.valid <= 1'b0;
        ex_meta.valid <= 1'b0;
      end else begin
        id_meta <= if_meta;
        ex_meta <= id_meta;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (resolve && ex_is_branch && (br_cnt != 16'hFFFF)) br_cnt <= br_cnt + 16'd1;
      if (mispredict && (mp_cnt != 16'hFFFF))              mp_cnt <= mp_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed scenarios plus random
// traffic compared each cycle against a behavioural model of the predictor.
module tb_btb_predictor;

  logic        clk, rst;
  logic [31:0] if_pc, ex_target;
  logic        if_valid, stall, ex_is_branch, ex_taken;
  logic        pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc;
  logic [15:0] br_cnt, mp_cnt;

  btb_predictor dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_valid(if_valid), .stall(stall),
    .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
    .pred_taken(pred_taken), .pred_target(pred_target), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .br_cnt(br_cnt), .mp_cnt(mp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: table as plain arrays, counters as integers 0..3,
  // in-flight instructions as two records.
  typedef struct {
    bit          v;
    logic [31:0] pc;
    bit          pt;
    logic [31:0] pn;
    bit          hit;
  } meta_t;

  bit          m_valid [32];
  logic [24:0] m_tag   [32];
  logic [31:0] m_tgt   [32];
  int          m_ctr   [32];
  meta_t       m_id, m_ex;
  int          m_br, m_mp;
  int          next_on_t [4] = '{1, 3, 3, 3};
  int          next_on_n [4] = '{0, 0, 0, 2};

  logic        o_pt, o_mp, f_pt;
  logic [31:0] o_pn, o_rd, f_pn;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    m_id.v = 1'b0;
    m_ex.v = 1'b0;
    m_br = 0;
    m_mp = 0;
  endfunction

  // One clock cycle: drive, compare against the model before the edge,
  // advance the model, then wait for the edge.
  task automatic cycle(input bit iv, input logic [31:0] pc, input bit st,
                       input bit br, input bit tk, input logic [31:0] tgt);
    int          idx, eidx;
    bit          e_hit, e_pt, e_mp, res;
    logic [31:0] e_pn, act, e_rd;
    if_valid = iv; if_pc = pc; stall = st;
    ex_is_branch = br; ex_taken = tk; ex_target = tgt;
    #1;
    idx   = int'(pc[6:2]);
    e_hit = m_valid[idx] && (m_tag[idx] == pc[31:7]);
    e_pt  = iv && e_hit && (m_ctr[idx] >= 2);
    e_pn  = e_pt ? m_tgt[idx] : pc + 32'd4;
    res   = m_ex.v && !st;
    act   = (br && tk) ? tgt : m_ex.pc + 32'd4;
    e_mp  = res && (act != m_ex.pn);
    e_rd  = res ? act : 32'd0;
    check("pred_taken",  32'(pred_taken),  32'(e_pt));
    check("pred_target", pred_target,      e_pn);
    check("mispredict",  32'(mispredict),  32'(e_mp));
    check("redirect_pc", redirect_pc,      e_rd);
    check("br_cnt",      32'(br_cnt),      32'(m_br));
    check("mp_cnt",      32'(mp_cnt),      32'(m_mp));
    o_pt = pred_taken; o_pn = pred_target; o_mp = mispredict; o_rd = redirect_pc;
    if (res) begin
      eidx = int'(m_ex.pc[6:2]);
      if (br) begin
        if (m_ex.hit) begin
          m_ctr[eidx] = tk ? next_on_t[m_ctr[eidx]] : next_on_n[m_ctr[eidx]];
          if (tk) m_tgt[eidx] = tgt;
        end else if (tk) begin
          m_valid[eidx] = 1'b1; m_tag[eidx] = m_ex.pc[31:7];
          m_tgt[eidx] = tgt;    m_ctr[eidx] = 2;
        end
        if (m_br < 65535) m_br++;
      end else if (m_ex.hit) begin
        m_valid[eidx] = 1'b0;
      end
      if (e_mp && m_mp < 65535) m_mp++;
    end
    if (!st) begin
      if (e_mp) begin
        m_ex.v = 1'b0;
        m_id.v = 1'b0;
      end else begin
        m_ex = m_id;
        m_id = '{iv, pc, e_pt, e_pn, e_hit};
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Fetch one instruction, let it travel through two bubbles, resolve it in EX.
  task automatic fetch_resolve(input logic [31:0] pc, input bit br, input bit tk,
                               input logic [31:0] tgt);
    cycle(1'b1, pc, 1'b0, 1'b0, 1'b0, 32'd0);
    f_pt = o_pt;
    f_pn = o_pn;
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 32'd0, 1'b0, br, tk, tgt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_pred_taken",  32'(pred_taken), 32'd0);
    check("rst_pred_target", pred_target,     if_pc + 32'd4);
    check("rst_mispredict",  32'(mispredict), 32'd0);
    check("rst_redirect",    redirect_pc,     32'd0);
    check("rst_br_cnt",      32'(br_cnt),     32'd0);
    check("rst_mp_cnt",      32'(mp_cnt),     32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mp_before;
    if_valid = 1'b1; if_pc = 32'h100; stall = 1'b0;
    ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = 32'd0;
    do_reset();

    // Cold miss, allocate WT, then a warm hit predicts the target.
    fetch_resolve(32'h100, 1'b1, 1'b1, 32'h200);
    check("cold_pred_target", f_pn, 32'h104);
    check("cold_mispredict",  32'(o_mp), 32'd1);
    check("cold_redirect",    o_rd, 32'h200);
    fetch_resolve(32'h100, 1'b1, 1'b1, 32'h200);
    check("warm_pred_target", f_pn, 32'h200);
    check("warm_no_mp",       32'(o_mp), 32'd0);

    // ST -> WT -> SNT -> WNT with N, N, T.
    mp_before = mp_cnt;
    fetch_resolve(32'h100, 1'b1, 1'b0, 32'd0);
    check("st_pred", 32'(f_pt), 32'd1);
    check("st_n_redirect", o_rd, 32'h104);
    fetch_resolve(32'h100, 1'b1, 1'b0, 32'd0);
    check("wt_pred", 32'(f_pt), 32'd1);
    check("nn_mp_delta", 32'(mp_cnt - mp_before), 32'd2);
    fetch_resolve(32'h100, 1'b1, 1'b1, 32'h200);
    check("snt_pred", 32'(f_pt), 32'd0);
    fetch_resolve(32'h100, 1'b1, 1'b1, 32'h200);
    check("wnt_pred", 32'(f_pt), 32'd0);

    // Alias kill: non-branch hitting a taken entry.
    fetch_resolve(32'h180, 1'b1, 1'b1, 32'h240);
    fetch_resolve(32'h180, 1'b0, 1'b0, 32'd0);
    check("alias_pred_target", f_pn, 32'h240);
    check("alias_mispredict",  32'(o_mp), 32'd1);
    check("alias_redirect",    o_rd, 32'h184);
    fetch_resolve(32'h180, 1'b0, 1'b0, 32'd0);
    check("alias_killed", 32'(f_pt), 32'd0);

    // Mispredict deferred by stall, then the younger ID slot is flushed.
    cycle(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 32'h500);
    check("stall_no_mp", 32'(o_mp), 32'd0);
    cycle(1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'h500);
    check("unstall_mp",       32'(o_mp), 32'd1);
    check("unstall_redirect", o_rd, 32'h500);
    check("stall_no_write",   o_pn, 32'h304);
    cycle(1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'h600);
    check("flushed_no_res", 32'(o_mp), 32'd0);
    check("alloc_after_unstall", o_pn, 32'h500);

    // Random traffic on a few indices/tags so hits, aliasing and flushes occur.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] pc, tgt;
      if (i == 2000) do_reset();
      pc  = ($urandom_range(0, 2) << 7) | ($urandom_range(0, 3) << 2);
      tgt = 32'h1000 + ($urandom_range(0, 3) << 6);
      cycle($urandom_range(0, 3) != 0, pc, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), tgt);
    end

    // Counter saturation, then asynchronous reset in the middle of the burst.
    do_reset();
    for (int i = 0; i < 65540; i++) cycle(1'b1, 32'h2000, 1'b0, 1'b1, 1'b0, 32'd0);
    check("br_cnt_saturated", 32'(br_cnt), 32'hFFFF);
    check("mp_cnt_none",      32'(mp_cnt), 32'd0);
    cycle(1'b1, 32'h2000, 1'b0, 1'b1, 1'b0, 32'd0);
    check("br_cnt_holds", 32'(br_cnt), 32'hFFFF);
    #2;
    do_reset();
    cycle(1'b1, 32'h2000, 1'b0, 1'b1, 1'b1, 32'h3000);
    check("post_rst_no_res", 32'(o_mp), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Fetch-side branch target buffer with 2-bit saturating direction counters, plus the resolution and update path that closes the loop from execute. It predicts next-PC for the instruction in IF and carries prediction metadata through ID to EX. In EX it compares the prediction against the actual outcome, raises `mispredict` with the correct `redirect_pc`, and updates the table. Sits between the PC mux (consumer of `pred_target` and `redirect_pc`) and the EX branch unit (producer of `ex_taken` and `ex_target`).

## Interface
- `ENTRIES`, 32, number of BTB entries (power of two)
- `XLEN`, 32, address width
- `IDX_W`, 5, log2(`ENTRIES`); index = `pc[IDX_W+1:2]`, tag = `pc[XLEN-1:IDX_W+2]`
- `clk  in  1`  single clock, rising edge
- `rst  in  1`  asynchronous, active-high reset
- `if_pc  in  XLEN`  PC of the instruction in IF
- `if_valid  in  1`  IF slot holds a real instruction
- `stall  in  1`  pipeline stall; freezes the metadata pipe and blocks resolution
- `ex_is_branch  in  1`  instruction in EX is a branch or jump
- `ex_taken  in  1`  actual branch outcome
- `ex_target  in  XLEN`  actual taken target
- `pred_taken  out  1`  IF prediction
- `pred_target  out  XLEN`  predicted next PC for IF
- `mispredict  out  1`  EX resolution disagrees with prediction
- `redirect_pc  out  XLEN`  correct next PC when `mispredict`
- `br_cnt  out  16`  resolved branches, saturating
- `mp_cnt  out  16`  mispredictions, saturating

## Operation
- Entry fields: {valid, tag, target[XLEN], state[2]}.
- Counter states: SNT=00, WNT=01, WT=10, ST=11.
- Prediction is taken iff `state[1]`.
- Counter transitions (team-standard; T = taken, N = not taken):
  - SNT: T→WNT, N→SNT
  - WNT: T→ST, N→SNT
  - WT: T→ST, N→SNT
  - ST: T→ST, N→WT
- Lookup (combinational):
  - hit = valid & tag match.
  - `pred_taken` = `if_valid` & hit & `state[1]`.
  - `pred_target` = `pred_taken` ? target : `if_pc`+4.
- Metadata pipe: two registered slots, IF→ID→EX. Each slot holds {valid, pc, pred_taken, pred_next, hit}. A slot advances only when `stall`=0.
- Resolution, when the EX slot is valid & `stall`=0:
  - actual_next = (`ex_is_branch` & `ex_taken`) ? `ex_target` : pc+4.
  - `mispredict` = (actual_next != pred_next).
  - `redirect_pc` = actual_next.
- Table update, at the resolving edge:
  - branch & hit: state ← next_state(state, `ex_taken`); target ← `ex_target` if taken.
  - branch & miss & taken: allocate with valid=1, tag, target, state=WT.
  - branch & miss & not taken: no write.
  - non-branch & hit: clear valid (alias kill).
- `br_cnt` increments on every resolved `ex_is_branch`. `mp_cnt` increments on every `mispredict`. Both hold at 0xFFFF.

## Timing
- Lookup is zero-latency, combinational from `if_pc`.
- Resolution outputs are combinational in the EX cycle. The table write and counter increments take effect on the following edge.
- Mispredict flush: on the mispredict edge, the ID slot and the EX slot load valid=0, so younger wrong-path metadata is discarded.
- Same-index lookup and update in one cycle: the lookup sees the pre-write contents (no bypass).
- `stall`=1:
  - slots hold their values
  - `mispredict`=0
  - no table write
  - no counter increment
- `stall` and a would-be mispredict in the same cycle: the mispredict is deferred until `stall` drops.
- Reset (asynchronous, effective immediately):
  - all entries valid=0
  - both slots valid=0
  - `br_cnt`=`mp_cnt`=0
  - `mispredict`=0
  - `pred_taken`=0
  - `pred_target`=`if_pc`+4
  - `redirect_pc`=0
- Reset mid-operation discards all in-flight metadata.

## Structure
- `bp_pkg`: `bp_state_t` (2-bit enum), `btb_entry_t` struct, `bp_meta_t` struct, `bp_next_state()` function.
- Sub-module `btb_array`: entry storage with one async read port and one sync write port, and async clear on `rst`.
- Top level: metadata pipe, resolution compare, update/allocate logic, performance counters.

## Test plan
- Reset, then `if_pc`=0x100 → `pred_taken`=0, `pred_target`=0x104, `br_cnt`=`mp_cnt`=0.
- Branch at 0x100 taken to 0x200 resolves in EX with a cold table → `mispredict`=1, `redirect_pc`=0x200, entry allocated WT. Next fetch of 0x100 → `pred_target`=0x200.
- Same branch resolves N, N, T starting from ST → states ST→WT→SNT→WNT. Predictions T, T, N. `mp_cnt` +2 (the N at ST and the N at WT).
- Non-branch at 0x180 aliases a valid entry with a matching tag and predicts taken → `mispredict`=1, `redirect_pc`=0x184, entry valid cleared.
- Mispredict while `stall`=1 → no `mispredict`, no table write. Asserts on the first cycle with `stall`=0, and the ID slot is flushed at that edge.
- Preload `br_cnt`=0xFFFF via 65535 resolutions, then one more → holds at 0xFFFF. Assert `rst` mid-burst → all outputs return to reset values asynchronously.
